// File: rtl/spram_arbiter.sv
// Clear sequencer and round-robin two-requester arbiter in front of a single-port RAM
// with registered read; all RAM-side controls are registered.
module spram_arbiter #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_start,
    output logic              init_done,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [AWIDTH-1:0] a_addr,
    input  logic [DWIDTH-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DWIDTH-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [AWIDTH-1:0] b_addr,
    input  logic [DWIDTH-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DWIDTH-1:0] b_rdata,
    output logic              ram_wr_en,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_wr_data,
    input  logic [DWIDTH-1:0] ram_rd_data
);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [AWIDTH:0]   cnt;
    logic [AWIDTH:0]   cnt_next;
    logic              prio;
    logic              prio_next;
    logic              wr_en_next;
    logic [AWIDTH-1:0] addr_next;
    logic [DWIDTH-1:0] wdata_next;
    logic [1:0]        tag_rd;
    logic [1:0]        tag_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= INIT;
            cnt         <= '0;
            prio        <= 1'b0;
            ram_wr_en   <= 1'b0;
            ram_addr    <= '0;
            ram_wr_data <= '0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            prio        <= prio_next;
            ram_wr_en   <= wr_en_next;
            ram_addr    <= addr_next;
            ram_wr_data <= wdata_next;
        end
    end

    // prio = 0 favours A, 1 favours B; the winner always drops to lowest priority.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        prio_next  = prio;
        a_gnt      = 1'b0;
        b_gnt      = 1'b0;
        wr_en_next = 1'b0;
        addr_next  = ram_addr;
        wdata_next = ram_wr_data;
        case (state)
            INIT: begin
                wr_en_next = 1'b1;
                addr_next  = cnt[AWIDTH-1:0];
                wdata_next = '0;
                cnt_next   = cnt + 1'b1;
                if (cnt == (AWIDTH+1)'(DEPTH - 1)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (init_start) begin
                    state_next = INIT;
                    cnt_next   = '0;
                end else if (a_req && (!b_req || !prio)) begin
                    a_gnt      = 1'b1;
                    prio_next  = 1'b1;
                    wr_en_next = a_we;
                    addr_next  = a_addr;
                    wdata_next = a_we ? a_wdata : '0;
                end else if (b_req) begin
                    b_gnt      = 1'b1;
                    prio_next  = 1'b0;
                    wr_en_next = b_we;
                    addr_next  = b_addr;
                    wdata_next = b_we ? b_wdata : '0;
                end
            end
            default: begin
                state_next = INIT;
                cnt_next   = '0;
            end
        endcase
    end

    // Tags keep flowing through a re-init so in-flight reads still return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_rd <= '0;
            tag_b  <= '0;
        end else begin
            tag_rd <= {tag_rd[0], (a_gnt && !a_we) || (b_gnt && !b_we)};
            tag_b  <= {tag_b[0], b_gnt};
        end
    end

    assign init_done = (state == RUN);
    assign a_rvalid  = tag_rd[1] && !tag_b[1];
    assign b_rvalid  = tag_rd[1] && tag_b[1];
    assign a_rdata   = a_rvalid ? ram_rd_data : '0;
    assign b_rdata   = b_rvalid ? ram_rd_data : '0;

endmodule

// File: tb/tb_spram_arbiter.sv
// Bench for spram_arbiter: directed scenarios plus random traffic, checked each cycle
// against a transaction-level model (expected memory image and a return queue).
module tb_spram_arbiter;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_start = 1'b0;
    logic          init_done;
    logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          ram_wr_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wr_data;
    logic [DW-1:0] ram_rd_data = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spram_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .init_start(init_start), .init_done(init_done),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_wr_en(ram_wr_en), .ram_addr(ram_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_data(ram_rd_data)
    );

    // Single-port RAM: registered read, read data forced to 0 in write cycles.
    logic [DW-1:0] ram [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = 8'hFF;
    end
    always @(posedge clk) begin
        if (ram_wr_en) begin
            ram[ram_addr] <= ram_wr_data;
            ram_rd_data   <= '0;
        end else begin
            ram_rd_data <= ram[ram_addr];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level model: expected memory contents and queue of pending returns.
    typedef struct packed {
        int       due;
        logic     owner;
        logic [7:0] data;
    } ret_t;

    ret_t       rq[$];
    logic [7:0] m_mem [DEPTH];
    bit         m_init = 1'b1;
    int         m_cnt  = 0;
    bit         m_prio = 1'b0;
    int         cyc    = 0;
    logic       e_we    = 1'b0;
    logic [7:0] e_addr  = '0;
    logic [7:0] e_wdata = '0;

    always @(negedge clk) begin : model
        logic eg_a, eg_b, ev_a, ev_b;
        logic [7:0] ed_a, ed_b, w_addr, w_data;
        logic w_we;
        ret_t r;
        cyc++;
        eg_a = 1'b0; eg_b = 1'b0; ev_a = 1'b0; ev_b = 1'b0; ed_a = '0; ed_b = '0;
        if (!rst_n) begin
            m_init = 1'b1; m_cnt = 0; m_prio = 1'b0; rq.delete();
            e_we = 1'b0; e_addr = '0; e_wdata = '0;
        end else begin
            if (!m_init && !init_start) begin
                if (a_req && (!b_req || !m_prio)) eg_a = 1'b1;
                else if (b_req) eg_b = 1'b1;
            end
            if (rq.size() > 0 && rq[0].due == cyc) begin
                r = rq.pop_front();
                if (r.owner) begin ev_b = 1'b1; ed_b = r.data; end
                else begin ev_a = 1'b1; ed_a = r.data; end
            end
        end
        checkOutput("init_done", 32'(init_done), 32'(!m_init));
        checkOutput("a_gnt", 32'(a_gnt), 32'(eg_a));
        checkOutput("b_gnt", 32'(b_gnt), 32'(eg_b));
        checkOutput("a_rvalid", 32'(a_rvalid), 32'(ev_a));
        checkOutput("b_rvalid", 32'(b_rvalid), 32'(ev_b));
        checkOutput("a_rdata", 32'(a_rdata), 32'(ed_a));
        checkOutput("b_rdata", 32'(b_rdata), 32'(ed_b));
        checkOutput("ram_wr_en", 32'(ram_wr_en), 32'(e_we));
        checkOutput("ram_addr", 32'(ram_addr), 32'(e_addr));
        checkOutput("ram_wr_data", 32'(ram_wr_data), 32'(e_wdata));
        if (rst_n) begin
            if (m_init) begin
                e_we = 1'b1; e_addr = 8'(m_cnt); e_wdata = '0;
                m_mem[m_cnt] = '0;
                if (m_cnt == DEPTH - 1) m_init = 1'b0;
                m_cnt++;
            end else if (init_start) begin
                m_init = 1'b1; m_cnt = 0; e_we = 1'b0;
            end else if (eg_a || eg_b) begin
                w_we   = eg_a ? a_we : b_we;
                w_addr = eg_a ? a_addr : b_addr;
                w_data = eg_a ? a_wdata : b_wdata;
                e_we   = w_we;
                e_addr = w_addr;
                e_wdata = w_we ? w_data : '0;
                if (w_we) m_mem[w_addr] = w_data;
                else rq.push_back('{cyc + 2, eg_b, m_mem[w_addr]});
                m_prio = eg_a;
            end else begin
                e_we = 1'b0;
            end
        end
    end

    task automatic applyStimulus(input logic ar, input logic aw, input logic [7:0] aa, input logic [7:0] ad,
                                 input logic br, input logic bw, input logic [7:0] ba, input logic [7:0] bd,
                                 input logic is);
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
        init_start = is;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic waitDone(input string name, output int n);
        n = 0;
        while (n < 400 && !init_done) begin
            nextCycle();
            sample();
            n++;
        end
        checkOutput(name, 32'(init_done), 32'd1);
    endtask

    initial begin
        int   n;
        logic ar, aw, br, bw, ga, gb, is;
        logic [7:0] aa, ad, ba, bd;

        idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Clear after reset: 256 writes, done on the 257th cycle after release.
        n = 0;
        while (n < 400) begin
            sample();
            n++;
            if (init_done) break;
        end
        checkOutput("init_done_cycle", 32'(n), 32'd257);
        checkOutput("last_clear_addr", 32'(ram_addr), 32'hFF);
        checkOutput("last_clear_we", 32'(ram_wr_en), 32'd1);

        // A writes 0x5A to 0x10, then reads it back.
        nextCycle(); applyStimulus(1, 1, 8'h10, 8'h5A, 0, 0, 0, 0, 0); sample();
        checkOutput("a_write_gnt", 32'(a_gnt), 32'd1);
        nextCycle(); applyStimulus(1, 0, 8'h10, 8'h00, 0, 0, 0, 0, 0); sample();
        checkOutput("wr_pins_en", 32'(ram_wr_en), 32'd1);
        checkOutput("wr_pins_addr", 32'(ram_addr), 32'h10);
        checkOutput("wr_pins_data", 32'(ram_wr_data), 32'h5A);
        nextCycle(); idle(); sample();
        nextCycle(); sample();
        checkOutput("a_rvalid_5a", 32'(a_rvalid), 32'd1);
        checkOutput("a_rdata_5a", 32'(a_rdata), 32'h5A);
        checkOutput("b_rvalid_quiet", 32'(b_rvalid), 32'd0);

        // Cleared word reads back as zero.
        nextCycle(); applyStimulus(1, 0, 8'h80, 8'h00, 0, 0, 0, 0, 0); sample();
        nextCycle(); idle(); sample();
        nextCycle(); sample();
        checkOutput("cleared_rvalid", 32'(a_rvalid), 32'd1);
        checkOutput("cleared_rdata", 32'(a_rdata), 32'h00);

        // Interleaved reads return to the right owner.
        nextCycle(); applyStimulus(1, 1, 8'h01, 8'h11, 0, 0, 0, 0, 0); sample();
        nextCycle(); applyStimulus(0, 0, 0, 0, 1, 1, 8'h02, 8'h22, 0); sample();
        nextCycle(); applyStimulus(1, 0, 8'h01, 0, 0, 0, 0, 0, 0); sample();
        checkOutput("il_a_gnt", 32'(a_gnt), 32'd1);
        nextCycle(); applyStimulus(0, 0, 0, 0, 1, 0, 8'h02, 0, 0); sample();
        checkOutput("il_b_gnt", 32'(b_gnt), 32'd1);
        nextCycle(); idle(); sample();
        checkOutput("il_a_rvalid", 32'(a_rvalid), 32'd1);
        checkOutput("il_a_rdata", 32'(a_rdata), 32'h11);
        checkOutput("il_b_quiet", 32'(b_rvalid), 32'd0);
        nextCycle(); sample();
        checkOutput("il_b_rvalid", 32'(b_rvalid), 32'd1);
        checkOutput("il_b_rdata", 32'(b_rdata), 32'h22);
        checkOutput("il_a_quiet", 32'(a_rvalid), 32'd0);

        // Contention alternates A, B, ...; then B alone, then A wins the next conflict.
        for (int i = 0; i < 6; i++) begin
            nextCycle(); applyStimulus(1, 0, 8'h01, 0, 1, 0, 8'h02, 0, 0); sample();
            checkOutput("cont_a_gnt", 32'(a_gnt), 32'(i % 2 == 0));
            checkOutput("cont_b_gnt", 32'(b_gnt), 32'(i % 2 == 1));
        end
        for (int i = 0; i < 3; i++) begin
            nextCycle(); applyStimulus(0, 0, 0, 0, 1, 0, 8'h02, 0, 0); sample();
            checkOutput("b_alone_gnt", 32'(b_gnt), 32'd1);
        end
        nextCycle(); applyStimulus(1, 0, 8'h01, 0, 1, 0, 8'h02, 0, 0); sample();
        checkOutput("a_after_b_gnt", 32'(a_gnt), 32'd1);

        // Re-init with a read in flight and A waiting.
        nextCycle(); applyStimulus(0, 0, 0, 0, 1, 0, 8'h02, 0, 0); sample();
        checkOutput("ri_b_gnt", 32'(b_gnt), 32'd1);
        nextCycle(); applyStimulus(1, 0, 8'h01, 0, 0, 0, 0, 0, 1); sample();
        checkOutput("ri_no_a_gnt", 32'(a_gnt), 32'd0);
        nextCycle(); applyStimulus(1, 0, 8'h01, 0, 0, 0, 0, 0, 0); sample();
        checkOutput("ri_b_rvalid", 32'(b_rvalid), 32'd1);
        checkOutput("ri_b_rdata", 32'(b_rdata), 32'h22);
        waitDone("ri_done", n);
        checkOutput("ri_len", 32'(n), 32'd256);
        checkOutput("ri_a_gnt_at_done", 32'(a_gnt), 32'd1);

        // Asynchronous reset during a read.
        nextCycle(); applyStimulus(1, 0, 8'h01, 0, 0, 0, 0, 0, 0); sample();
        nextCycle(); idle();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("ar_done", 32'(init_done), 32'd0);
        checkOutput("ar_wr_en", 32'(ram_wr_en), 32'd0);
        checkOutput("ar_addr", 32'(ram_addr), 32'd0);
        checkOutput("ar_a_rvalid", 32'(a_rvalid), 32'd0);
        repeat (3) nextCycle();
        rst_n = 1'b1;
        sample();
        checkOutput("rel_wr_en0", 32'(ram_wr_en), 32'd0);
        nextCycle(); sample();
        checkOutput("rel_wr_en1", 32'(ram_wr_en), 32'd1);
        checkOutput("rel_addr0", 32'(ram_addr), 32'd0);
        nextCycle(); sample();
        checkOutput("rel_addr1", 32'(ram_addr), 32'd1);
        waitDone("rel_done", n);

        // Random traffic on a small address window, occasional re-init.
        ar = 0; aw = 0; aa = 0; ad = 0; br = 0; bw = 0; ba = 0; bd = 0; ga = 0; gb = 0;
        for (int i = 0; i < 3000; i++) begin
            nextCycle();
            if (!ar || ga) begin
                ar = ($urandom_range(0, 99) < 60);
                aw = 1'($urandom_range(0, 1));
                aa = 8'($urandom_range(0, 15));
                ad = 8'($urandom);
            end
            if (!br || gb) begin
                br = ($urandom_range(0, 99) < 60);
                bw = 1'($urandom_range(0, 1));
                ba = 8'($urandom_range(0, 15));
                bd = 8'($urandom);
            end
            is = ($urandom_range(0, 999) == 0);
            applyStimulus(ar, aw, aa, ad, br, bw, ba, bd, is);
            sample();
            ga = a_gnt;
            gb = b_gnt;
        end
        nextCycle(); idle();
        repeat (4) nextCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spram_arbiter.md
# spram_arbiter

Sequencer and two-requester arbiter in front of the team's single-port RAM (registered read, one access per clock). After reset, or on request, it clears every RAM word to zero, then shares the RAM between requesters A and B with round-robin priority. It returns read data to the requester that issued the read. All RAM-side signals are registered, so the RAM sees clean, reset-defined controls.

## Interface
- DWIDTH, 8: data width; matches the RAM.
- AWIDTH, 8: address width; matches the RAM address port.
- DEPTH, 256: words cleared by the init sequence; DEPTH ≤ 2^AWIDTH.

- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- init_start  in  1  single-cycle pulse; re-runs the clear sequence.
- init_done  out  1  high while in RUN.
- a_req / b_req  in  1  access request, held until granted.
- a_we / b_we  in  1  1 = write, 0 = read; stable while req is high.
- a_addr / b_addr  in  AWIDTH  access address.
- a_wdata / b_wdata  in  DWIDTH  write data.
- a_gnt / b_gnt  out  1  combinational; request accepted this cycle.
- a_rvalid / b_rvalid  out  1  read data valid this cycle.
- a_rdata / b_rdata  out  DWIDTH  read data; 0 when the matching rvalid is low.
- ram_wr_en  out  1  registered RAM write enable.
- ram_addr  out  AWIDTH  registered RAM address.
- ram_wr_data  out  DWIDTH  registered RAM write data.
- ram_rd_data  in  DWIDTH  RAM read data; registered in the RAM, forced to 0 by the RAM in write cycles.

## Operation
- **States:** INIT, RUN. Reset enters INIT with clear counter cnt = 0.
- **INIT:**
  - Each cycle, load ram_wr_en = 1, ram_addr = cnt, ram_wr_data = 0, then increment cnt.
  - When cnt == DEPTH-1, the last write is loaded and the state moves to RUN.
  - No grants are issued in INIT. init_start is ignored in INIT.
- **RUN:**
  - init_done = 1.
  - An init_start pulse moves the state to INIT with cnt = 0. No grant is issued in that cycle, even if requests are pending.
- **Arbitration (RUN only):**
  - Priority pointer prio ∈ {A, B}; reset value A.
  - Only one requester asserting: that requester is granted.
  - Both asserting: the requester named by prio is granted.
  - On any grant, prio moves to the other requester (last winner becomes lowest priority).
  - At most one gnt is high per cycle. Every cycle in RUN with a request pending produces a grant (no bubbles).
- **Command issue:** on grant cycle N, load ram_wr_en = we, ram_addr = addr, ram_wr_data = wdata (0 for reads) of the winner. With no grant, load ram_wr_en = 0 and hold ram_addr / ram_wr_data.
- **Read return:**
  - A two-stage tag pipeline records {read, owner} per grant.
  - A read granted in cycle N asserts owner_rvalid in cycle N+2, with owner_rdata = ram_rd_data.
- **In-flight reads across init_start:** reads granted before the pulse still return their data and rvalid.
- **Width rules:** cnt is an AWIDTH+1 bit counter, so DEPTH = 2^AWIDTH terminates without wrap. Addresses pass through unmodified.

## Timing
- **Reset values:**
  - init_done 0; all gnt 0; all rvalid 0; all rdata 0.
  - ram_wr_en 0, ram_addr 0, ram_wr_data 0.
  - State INIT, cnt 0, prio A, tag pipeline empty.
- **First INIT write:** the first rising edge after rst_n deasserts loads addr 0. The last clear write (addr DEPTH-1) is on the RAM pins in cycle DEPTH+1; init_done rises in the same cycle. The first grant is possible in that cycle.
- **Write latency:** a write granted in cycle N is on the RAM pins in cycle N+1 and is committed at the end of cycle N+1.
- **Read latency:** 2 cycles, grant to rvalid. Throughput is one access per cycle.
- **Write-then-read, same address:** write granted in N, read granted in N+1. The read returns the new data in N+3.
- **Reset mid-operation:** asynchronous return to reset values. Pending tags are discarded and no rvalid is produced.

## Test plan
- **Reset clear:** preload RAM with 0xFF, release reset (DEPTH=256) → 256 consecutive writes of 0 to addr 0..255, init_done high on cycle 257. A read of addr 0x80 afterwards returns 0x00.
- **Single requester:**
  - A writes 0x5A to 0x10 in cycle N → ram_wr_en = 1, addr 0x10, data 0x5A in N+1.
  - A reads 0x10 in N+1 → a_rvalid in N+3 with 0x5A; b_rvalid stays 0.
- **Contention:** A and B both request continuously after reset → grants A, B, A, B, ... every cycle. B held alone for 3 cycles → 3 consecutive B grants. A arriving afterwards wins the next conflict.
- **Interleaved reads:** A reads 0x01 (holds 0x11) in N, B reads 0x02 (holds 0x22) in N+1 → a_rvalid with 0x11 in N+2, b_rvalid with 0x22 in N+3, never crossed.
- **Re-init:** B read granted in N, init_start in N+1 with A requesting → no grant in N+1, b_rvalid in N+2 with the old data, full clear runs, then A is granted after init_done.
- **Async reset:** assert rst_n during a read at cycle N+1 → rvalid never asserts, all outputs at reset values immediately, init restarts at addr 0 on release.
